wb_mem_master: RTL



---
 rtl/wb_mem_master_pkg.sv | 12 +
 rtl/wb_mem_master_timeout_cnt.sv | 20 ++
 rtl/wb_mem_master.sv | 82 ++++++++
 3 files changed

// File: rtl/wb_mem_master_pkg.sv
// wb_mem_master_pkg: shared state encoding and default widths/timeout for wb_mem_master.
package wb_mem_master_pkg;
   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CALIB_WAIT = 2'd1,
      ACTIVE     = 2'd2,
      RELEASE    = 2'd3
   } state_t;
   localparam int DEF_ADDR_W         = 27;
   localparam int DEF_DATA_W         = 32;
   localparam int DEF_TIMEOUT_CYCLES = 1024;
endpackage

// File: rtl/wb_mem_master_timeout_cnt.sv
// wb_timeout_cnt: ACTIVE-cycle counter for wb_mem_master, flags expiry at LIMIT-1.
module wb_timeout_cnt
   import wb_mem_master_pkg::*;
#(
   parameter int LIMIT = DEF_TIMEOUT_CYCLES
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   output logic o_expired
);
   localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   logic [CW-1:0] r_cnt;
   always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) r_cnt <= '0;
      else if (i_clr) r_cnt <= '0;
      else if (i_en) r_cnt <= r_cnt + 1'b1;
   assign o_expired = r_cnt == CW'(LIMIT - 1);
endmodule

// File: rtl/wb_mem_master.sv
// wb_mem_master: one CPU single-word request -> one classic Wishbone cycle, gated by DDR2 calibration.
// Optional bus timeout enabled by defining WB_MASTER_TIMEOUT_EN.
module wb_mem_master
   import wb_mem_master_pkg::*;
#(
   parameter int ADDR_W         = DEF_ADDR_W,
   parameter int DATA_W         = DEF_DATA_W,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              wb_clk_i,
   input  logic              wb_rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [3:0]        sel_i,
   input  logic [ADDR_W-1:0] adr_i,
   input  logic [DATA_W-1:0] dat_i,
   input  logic              calib_i,
   output logic              busy_o,
   output logic              done_o,
   output logic [DATA_W-1:0] rdata_o,
   output logic              err_o,
   output logic              wb_cyc_o,
   output logic              wb_stb_o,
   output logic              wb_we_o,
   output logic [3:0]        wb_sel_o,
   output logic [ADDR_W-1:0] wb_adr_o,
   output logic [DATA_W-1:0] wb_dat_o,
   input  logic [DATA_W-1:0] wb_dat_i,
   input  logic              wb_ack_i
);
   state_t r_state, w_next;
   logic   w_ack, w_to;
   assign w_ack = (r_state == ACTIVE) && wb_ack_i;
`ifdef WB_MASTER_TIMEOUT_EN
   logic w_exp;
   wb_timeout_cnt #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
      .i_clk     (wb_clk_i),
      .i_rst     (wb_rst_i),
      .i_clr     (r_state != ACTIVE),
      .i_en      (!wb_ack_i),
      .o_expired (w_exp)
   );
   assign w_to = (r_state == ACTIVE) && !wb_ack_i && w_exp;
`else
   assign w_to = 1'b0 && (TIMEOUT_CYCLES > 0);
`endif
   always_comb
      w_next = (r_state == IDLE)       ? (req_i ? (calib_i ? ACTIVE : CALIB_WAIT) : IDLE)
             : (r_state == CALIB_WAIT) ? (calib_i ? ACTIVE : CALIB_WAIT)
             : (r_state == ACTIVE)     ? ((wb_ack_i || w_to) ? RELEASE : ACTIVE)
             : IDLE;
   // RELEASE ignores ack: the responder still holds it high from the finished cycle
   always_ff @(posedge wb_clk_i or posedge wb_rst_i)
      if (wb_rst_i) begin
         r_state  <= IDLE;
         busy_o   <= 1'b0;
         done_o   <= 1'b0;
         err_o    <= 1'b0;
         rdata_o  <= '0;
         wb_cyc_o <= 1'b0;
         wb_stb_o <= 1'b0;
         wb_we_o  <= 1'b0;
         wb_sel_o <= '0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
      end else begin
         r_state  <= w_next;
         busy_o   <= w_next != IDLE;
         done_o   <= w_next == RELEASE;
         err_o    <= w_to;
         wb_cyc_o <= w_next == ACTIVE;
         wb_stb_o <= w_next == ACTIVE;
         if (r_state == IDLE && req_i) begin
            wb_we_o  <= we_i;
            wb_sel_o <= sel_i;
            wb_adr_o <= adr_i;
            wb_dat_o <= dat_i;
         end
         if (w_ack && !wb_we_o) rdata_o <= wb_dat_i;
         else if (w_to) rdata_o <= '0;
      end
endmodule
